// File: rtl/wave_shaper_if.sv
// Phase-address input and shaped-sample output bundle for wave_shaper.
// The sync marker exists only when WAVE_SHAPER_SYNC_OUT_EN is defined.
interface wave_shaper_if #(
    parameter int AW = 12
);
    logic          up;
    logic [AW-1:0] address;
    logic [1:0]    shape;
    logic [3:0]    amp;
    logic [AW-1:0] sample;
    logic          sample_valid;
`ifdef WAVE_SHAPER_SYNC_OUT_EN
    logic          sync;

    modport master (output up, address, shape, amp, input sample, sample_valid, sync);
    modport slave  (input up, address, shape, amp, output sample, sample_valid, sync);
`else
    modport master (output up, address, shape, amp, input sample, sample_valid);
    modport slave  (input up, address, shape, amp, output sample, sample_valid);
`endif
endinterface

// File: rtl/wave_shaper.sv
// Phase address -> saw/triangle/square/midscale sample, scaled by (amp+1)/16 about midscale; optional sync via WAVE_SHAPER_SYNC_OUT_EN.
// Two registered stages, one sample per up strobe; no backpressure, the consumer must take every sample_valid pulse.
module wave_shaper #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    wave_shaper_if.slave  bus
);
    localparam logic [1:0]    SH_SAW = 2'b00;
    localparam logic [1:0]    SH_TRI = 2'b01;
    localparam logic [1:0]    SH_SQR = 2'b10;
    localparam logic [AW-1:0] MID    = {1'b1, {(AW-1){1'b0}}};

    logic [1:0]          r_shape_act;
    logic [3:0]          r_amp_act;
    logic [AW-1:0]       r_raw;
    logic [3:0]          r_amp1;
    logic                r_valid1;
    logic [AW-1:0]       r_sample;
    logic                r_sample_vld;

    logic                w_addr_zero;
    logic [1:0]          w_shape_eff;
    logic [3:0]          w_amp_eff;
    logic [AW-1:0]       w_raw;
    logic signed [AW+3:0] w_s;
    logic signed [5:0]   w_gain;
    logic [AW-1:0]       w_q;
    logic [AW-1:0]       w_sample;

    // A period boundary takes the new settings in the same cycle as its own sample.
    assign w_addr_zero = (bus.address == '0);
    assign w_shape_eff = w_addr_zero ? bus.shape : r_shape_act;
    assign w_amp_eff   = w_addr_zero ? bus.amp   : r_amp_act;

    always_comb begin
        w_raw = MID;
        case (w_shape_eff)
            SH_SAW:  w_raw = bus.address;
            SH_TRI:  w_raw = bus.address[AW-1] ? ~{bus.address[AW-2:0], 1'b0}
                                               :  {bus.address[AW-2:0], 1'b0};
            SH_SQR:  w_raw = bus.address[AW-1] ? '0 : '1;
            default: w_raw = MID;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shape_act <= SH_SAW;
            r_amp_act   <= 4'hF;
            r_raw       <= MID;
            r_amp1      <= 4'hF;
            r_valid1    <= 1'b0;
        end else begin
            r_valid1 <= bus.up;
            if (bus.up) begin
                r_shape_act <= w_shape_eff;
                r_amp_act   <= w_amp_eff;
                r_raw       <= w_raw;
                r_amp1      <= w_amp_eff;
            end
        end
    end

    // Offset-binary to two's complement is an MSB flip; the 16-bit product cannot overflow for gain <= 16.
    assign w_s      = {{4{~r_raw[AW-1]}}, ~r_raw[AW-1], r_raw[AW-2:0]};
    assign w_gain   = {2'b00, r_amp1} + 6'd1;
    assign w_q      = AW'((w_s * w_gain) >>> 4);
    assign w_sample = {~w_q[AW-1], w_q[AW-2:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sample     <= MID;
            r_sample_vld <= 1'b0;
        end else begin
            r_sample_vld <= r_valid1;
            if (r_valid1) begin
                r_sample <= w_sample;
            end
        end
    end

    assign bus.sample       = r_sample;
    assign bus.sample_valid = r_sample_vld;

`ifdef WAVE_SHAPER_SYNC_OUT_EN
    logic r_sync1;
    logic r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync  <= 1'b0;
        end else begin
            if (bus.up) begin
                r_sync1 <= w_addr_zero;
            end
            r_sync <= r_valid1 & r_sync1;
        end
    end

    assign bus.sync = r_sync;
`endif
endmodule

// File: tb/tb_wave_shaper.sv
// Directed-vector bench for wave_shaper with hand-computed expected samples.
module tb_wave_shaper;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    wave_shaper_if #(.AW(12)) ws_if ();

    wave_shaper #(.AW(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ws_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One up strobe, then verify the two-edge latency and single-cycle valid pulse.
    task automatic send(input logic [11:0] addr, input logic [1:0] shp, input logic [3:0] amp,
                        input logic [11:0] exp, input string tag);
        @(negedge clk);
        ws_if.up      = 1'b1;
        ws_if.address = addr;
        ws_if.shape   = shp;
        ws_if.amp     = amp;
        @(negedge clk);
        ws_if.up = 1'b0;
        chk({tag, "_vld_early"}, {15'd0, ws_if.sample_valid}, 16'd0);
        @(negedge clk);
        chk({tag, "_sample"}, {4'd0, ws_if.sample}, {4'd0, exp});
        chk({tag, "_vld"}, {15'd0, ws_if.sample_valid}, 16'd1);
`ifdef WAVE_SHAPER_SYNC_OUT_EN
        chk({tag, "_sync"}, {15'd0, ws_if.sync}, {15'd0, (addr == 12'h000)});
`endif
        @(negedge clk);
        chk({tag, "_vld_drop"}, {15'd0, ws_if.sample_valid}, 16'd0);
    endtask

    initial begin
        ws_if.up      = 1'b0;
        ws_if.address = 12'h000;
        ws_if.shape   = 2'b00;
        ws_if.amp     = 4'hF;

        #12;
        chk("reset_sample", {4'd0, ws_if.sample}, 16'h0800);
        chk("reset_vld", {15'd0, ws_if.sample_valid}, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        send(12'h000, 2'b00, 4'hF, 12'h000, "saw0");
        send(12'h123, 2'b00, 4'hF, 12'h123, "saw123");

        send(12'h000, 2'b01, 4'hF, 12'h000, "tri0");
        send(12'h400, 2'b01, 4'hF, 12'h800, "tri400");
        send(12'h7FF, 2'b01, 4'hF, 12'hFFE, "tri7FF");
        send(12'h800, 2'b01, 4'hF, 12'hFFF, "tri800");
        send(12'hC00, 2'b01, 4'hF, 12'h7FF, "triC00");

        // Three back-to-back strobes: valid must stay high for three cycles.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 4) begin
                chk("b2b_vld", {15'd0, ws_if.sample_valid}, 16'd1);
                chk("b2b_sample", {4'd0, ws_if.sample}, 16'(((k - 1) * 2) << 8));
            end
            if (k == 5) begin
                chk("b2b_vld_end", {15'd0, ws_if.sample_valid}, 16'd0);
            end
            ws_if.up      = (k < 3);
            ws_if.address = 12'((k + 1) << 8);
        end
        ws_if.up = 1'b0;

        send(12'h000, 2'b10, 4'h7, 12'hBFF, "sqr0");
        send(12'h100, 2'b10, 4'h7, 12'hBFF, "sqr100");
        send(12'h900, 2'b10, 4'h7, 12'h400, "sqr900");

        send(12'h000, 2'b11, 4'h2, 12'h800, "off0");
        send(12'hABC, 2'b00, 4'hF, 12'h800, "offABC");
        send(12'hFFF, 2'b01, 4'h0, 12'h800, "offFFF");

        send(12'h000, 2'b00, 4'hF, 12'h000, "def_saw0");
        send(12'h500, 2'b10, 4'h3, 12'h500, "def500");
        send(12'hFFF, 2'b10, 4'h3, 12'hFFF, "defFFF");
        send(12'h000, 2'b10, 4'h3, 12'h9FF, "def_sqr0");
        send(12'h900, 2'b10, 4'h3, 12'h600, "def_sqr900");

        // Reset with a sample in flight: it must be discarded, settings back to saw/full gain.
        @(negedge clk);
        ws_if.up      = 1'b1;
        ws_if.address = 12'h7FF;
        @(negedge clk);
        ws_if.up = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_sample", {4'd0, ws_if.sample}, 16'h0800);
        chk("midrst_vld", {15'd0, ws_if.sample_valid}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("postrst_vld", {15'd0, ws_if.sample_valid}, 16'd0);
        end
        send(12'h123, 2'b10, 4'h3, 12'h123, "postrst_saw");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wave_shaper.md
Name: wave_shaper

Overview:
- Sits directly downstream of the modulo address counter.
- Converts each 12-bit phase address, qualified by the counter's `up` advance strobe, into a waveform sample: sawtooth, triangle, square, or midscale.
- Applies per-cycle amplitude scaling about midscale, so the result drives the DAC path.
- Two-stage pipeline, one sample per `up` strobe, throughput up to one sample per clock.

Parameters:
- AW, 12, address and sample width in bits; midscale is 2^(AW-1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- up  input  1  address-advance strobe from the address counter; address is captured when high.
- address  input  AW  phase address from the address counter.
- shape  input  2  requested waveform: 00 saw, 01 triangle, 10 square, 11 off (midscale).
- amp  input  4  requested amplitude; gain = (amp+1)/16.
- sample  output  AW  scaled waveform sample.
- sample_valid  output  1  one-cycle pulse per new sample.

Behaviour:
- Reset: rst low asynchronously forces the following, regardless of clk:
  - sample = 0x800, sample_valid = 0;
  - pipeline valids = 0;
  - active shape = 00, active amp = 0xF.
- On release, operation resumes on the next rising edge with `up` high.
- Stage 1, on a clk edge with `up` = 1:
  - If address == 0, load active shape and active amp from the shape/amp inputs first.
  - Compute raw (AW bits) from address using the active shape:
    - saw: raw = address.
    - triangle: if address[11]=0, raw = {address[10:0],0}; else raw = ~{address[10:0],0}.
    - square: if address[11]=0, raw = 0xFFF; else raw = 0x000.
    - off: raw = 0x800.
  - Register raw together with valid1 = 1. With `up` = 0, valid1 = 0 and raw holds.
- Stage 2, every edge:
  - s = raw − 0x800 (signed 12-bit).
  - p = s × (amp_act+1) (signed 17-bit).
  - q = p >>> 4 (arithmetic shift, rounds toward −inf).
  - sample = q + 0x800, registered only when valid1 = 1; otherwise sample holds.
  - sample_valid = valid1.
- Range: the result is always within 0..0xFFF, so no saturation is needed. amp = 0xF is the exact identity.
- Latency: `up` sampled high at edge N gives sample/sample_valid updated at edge N+2.
- Active amp is carried with the stage-1 data, so a sample is always scaled by the amp in force when its address was captured.
- shape/amp changes while address ≠ 0 have no effect until the next address-0 capture. This gives glitch-free waveform periods.
- Back-to-back `up` on consecutive cycles produces consecutive samples with sample_valid held high.
- Reset asserted mid-pipeline discards in-flight samples; no sample_valid is issued for them.
- address values are used as given, with no range checking; wrap handling belongs to the address counter.

Optional Feature:
- Macro: WAVE_SHAPER_SYNC_OUT_EN.
- Defined:
  - Adds output port `sync` (1 bit).
  - sync is high for exactly the sample_valid cycle of a sample whose captured address was 0.
  - Reset value 0; same 2-cycle latency.
  - Serves as a scope trigger / period marker.
- Undefined: the `sync` port and its pipeline register are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst low mid-stream with samples in flight -> sample = 0x800 and sample_valid = 0 immediately, no valid pulse after release until a new `up`.
- Saw, amp = 0xF: `up` with address = 0 (loads shape 00), then `up` with address = 0x123 -> two edges later sample = 0x123 with a single-cycle sample_valid; latency exactly 2 cycles.
- Triangle, amp = 0xF, one address per `up`:
  - 0x400 -> 0x800;
  - 0x7FF -> 0xFFE;
  - 0x800 -> 0xFFF;
  - 0xC00 -> 0x7FF.
  - Also `up` on consecutive cycles -> sample_valid held high continuously.
- Square, amp = 0x7:
  - address 0x100 -> 0xBFF;
  - address 0x900 -> 0x400.
  - Off shape -> 0x800 for any address.
- Deferred update: running saw, change shape to square and amp to 0x3 at address 0x500 -> samples stay saw at full gain through 0xFFF; from the address-0 sample onward, square at gain 4/16 (0x9FF / 0x600).
- With WAVE_SHAPER_SYNC_OUT_EN: sync pulses only alongside the address-0 sample, once per period. Without the macro, the build has no sync port.
